// File: rtl/axi2apb_pkg.sv
// Shared types and helpers for the AXI-to-APB command controller.
package axi2apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR,
        RESP
    } state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_t;

    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Number of 32-bit APB lanes carried by one AXI data beat.
    function automatic int lane_count(input int data_width);
        return data_width / 32;
    endfunction

    // Address bits needed to pick one lane (log2 of the lane count).
    function automatic int lane_bits(input int data_width);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << n) < data_width / 32) n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/axi2apb_rr_arb.sv
// Two-way round-robin arbiter between the read and write request paths.
module axi2apb_rr_arb
    import axi2apb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_rd,
    input  logic req_wr,
    input  logic advance,
    output logic gnt_rd,
    output logic gnt_wr
);

    grant_t last_grant;

    // Starting from WRITE lets a read win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= WRITE;
        end else if (advance) begin
            last_grant <= gnt_wr ? WRITE : READ;
        end
    end

    always_comb begin
        gnt_rd = req_rd & (~req_wr | (last_grant == WRITE));
        gnt_wr = req_wr & ~gnt_rd;
    end

endmodule

// File: rtl/axi2apb_cmd_ctrl.sv
// AXI-to-APB command controller: accepts single-beat AXI requests, arbitrates
// read vs write, sequences the APB phases and hands the command to the response stage.
module axi2apb_cmd_ctrl
    import axi2apb_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ID_WIDTH-1:0]     ARID,
    input  logic [31:0]                 ARADDR,
    input  logic [7:0]                  ARLEN,
    input  logic [2:0]                  ARSIZE,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]     AWID,
    input  logic [31:0]                 AWADDR,
    input  logic [7:0]                  AWLEN,
    input  logic [2:0]                  AWSIZE,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [APB_ADDR_WIDTH-1:0]   paddr,
    output logic [31:0]                 pwdata,
    output logic [3:0]                  pstrb,
    input  logic                        pready,
    output logic [AXI_ID_WIDTH-1:0]     cmd_id,
    output logic [APB_ADDR_WIDTH+3:0]   cmd_addr,
    output logic                        cmd_err,
    output logic                        cmd_err_go,
    input  logic                        finish_rd,
    input  logic                        finish_wr
);

    localparam int LANES = lane_count(AXI_DATA_WIDTH);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             gnt_rd;
    logic             gnt_wr;
    logic             grant;
    logic             grant_err;
    logic             rd_err;
    logic             wr_err;
    logic             timeout_hit;
    logic             finish_hit;
    logic [CNT_W-1:0] acc_cnt;
    logic [31:0]      lane_idx;
    logic [31:0]      lane_data;
    logic [3:0]       lane_strb;
    logic             unused_bits;

    assign unused_bits = ^ARADDR[31:APB_ADDR_WIDTH+4];

    axi2apb_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_rd  (ARVALID),
        .req_wr  (AWVALID & WVALID),
        .advance (grant),
        .gnt_rd  (gnt_rd),
        .gnt_wr  (gnt_wr)
    );

    assign grant       = (state == IDLE) & (gnt_rd | gnt_wr);
    assign rd_err      = (ARLEN != 8'd0) | (ARSIZE > 3'd2);
    assign wr_err      = (AWLEN != 8'd0) | (AWSIZE > 3'd2) | ~WLAST;
    assign grant_err   = gnt_wr ? wr_err : rd_err;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (acc_cnt == CNT_LAST);
    assign finish_hit  = pwrite ? finish_wr : finish_rd;

    // Pick the 32-bit slice of the AXI beat addressed by AWADDR.
    always_comb begin
        lane_idx  = (AWADDR >> 2) & 32'(LANES - 1);
        lane_data = WDATA[31:0];
        lane_strb = WSTRB[3:0];
        for (int i = 1; i < LANES; i++) begin
            if (lane_idx == 32'(i)) begin
                lane_data = WDATA[32*i +: 32];
                lane_strb = WSTRB[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ARREADY    = 1'b0;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        cmd_err_go = 1'b0;
        case (state)
            IDLE: begin
                ARREADY = gnt_rd;
                AWREADY = gnt_wr;
                WREADY  = gnt_wr;
                if (grant) state_nxt = grant_err ? ERR : SETUP;
            end
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready)           state_nxt = RESP;
                else if (timeout_hit) state_nxt = ERR;
            end
            ERR: begin
                cmd_err_go = 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                if (finish_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (state == ACCESS) begin
            acc_cnt <= acc_cnt + 1'b1;
        end else if ((state == RESP) && finish_hit) begin
            acc_cnt <= '0;
        end
    end

    // A pready coinciding with expiry keeps the transfer good.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else if (grant) begin
            cmd_err <= grant_err;
        end else if ((state == ACCESS) && !pready && timeout_hit) begin
            cmd_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_id   <= '0;
            cmd_addr <= '0;
            paddr    <= '0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            pstrb    <= '0;
        end else if (grant) begin
            cmd_id   <= gnt_wr ? AWID : ARID;
            cmd_addr <= gnt_wr ? AWADDR[APB_ADDR_WIDTH+3:0] : ARADDR[APB_ADDR_WIDTH+3:0];
            paddr    <= gnt_wr ? {AWADDR[APB_ADDR_WIDTH-1:2], 2'b00}
                               : {ARADDR[APB_ADDR_WIDTH-1:2], 2'b00};
            pwrite   <= gnt_wr;
            pwdata   <= gnt_wr ? lane_data : 32'd0;
            pstrb    <= gnt_wr ? lane_strb : 4'd0;
        end
    end

endmodule

// File: tb/tb_axi2apb_cmd_ctrl.sv
// Bench for axi2apb_cmd_ctrl: directed requests, a per-cycle protocol model, literal spot checks.
`timescale 1ns/1ps
module tb_axi2apb_cmd_ctrl;

    localparam int IDW = 6;
    localparam int DW  = 64;
    localparam int AW  = 12;
    localparam int TO  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IDW-1:0]  ARID = '0;
    logic [31:0]     ARADDR = '0;
    logic [7:0]      ARLEN = '0;
    logic [2:0]      ARSIZE = 3'd2;
    logic            ARVALID = 1'b0;
    logic            ARREADY;
    logic [IDW-1:0]  AWID = '0;
    logic [31:0]     AWADDR = '0;
    logic [7:0]      AWLEN = '0;
    logic [2:0]      AWSIZE = 3'd2;
    logic            AWVALID = 1'b0;
    logic            AWREADY;
    logic [DW-1:0]   WDATA = '0;
    logic [DW/8-1:0] WSTRB = '0;
    logic            WLAST = 1'b1;
    logic            WVALID = 1'b0;
    logic            WREADY;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [31:0]     pwdata;
    logic [3:0]      pstrb;
    logic            pready = 1'b1;
    logic [IDW-1:0]  cmd_id;
    logic [AW+3:0]   cmd_addr;
    logic            cmd_err;
    logic            cmd_err_go;
    logic            finish_rd = 1'b0;
    logic            finish_wr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    axi2apb_cmd_ctrl #(
        .AXI_ID_WIDTH   (IDW),
        .AXI_DATA_WIDTH (DW),
        .APB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_err(cmd_err), .cmd_err_go(cmd_err_go),
        .finish_rd(finish_rd), .finish_wr(finish_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of the command stream: what is outstanding and which protocol phase is due.
    bit             m_en = 0;
    bit             m_busy = 0;
    bit             m_done = 0;
    bit             m_last_wr = 1;
    bit             m_setup = 0;
    bit             m_access = 0;
    bit             m_go = 0;
    int             m_acc = 0;
    logic [IDW-1:0] e_id;
    logic [15:0]    e_addr;
    logic [AW-1:0]  e_paddr;
    logic [31:0]    e_pwdata;
    logic [3:0]     e_pstrb;
    bit             e_wr;
    bit             e_err;
    bit             c_er, c_ew, c_fin, n_setup, n_access, n_go;
    int             c_lane;

    always @(negedge clk) begin
        if (m_en) begin
            if (m_busy) begin
                c_er = 0;
                c_ew = 0;
            end else begin
                c_er = ARVALID && (!(AWVALID && WVALID) || m_last_wr);
                c_ew = AWVALID && WVALID && !c_er;
            end
            check("ARREADY", 64'(ARREADY), 64'(c_er));
            check("AWREADY", 64'(AWREADY), 64'(c_ew));
            check("WREADY", 64'(WREADY), 64'(c_ew));
            check("psel", 64'(psel), 64'(m_setup || m_access));
            check("penable", 64'(penable), 64'(m_access));
            check("cmd_err_go", 64'(cmd_err_go), 64'(m_go));
            if (m_busy) begin
                check("cmd_id", 64'(cmd_id), 64'(e_id));
                check("cmd_addr", 64'(cmd_addr), 64'(e_addr));
                check("pwrite", 64'(pwrite), 64'(e_wr));
                if (m_done || m_go) check("cmd_err", 64'(cmd_err), 64'(e_err));
                if (psel) begin
                    check("paddr", 64'(paddr), 64'(e_paddr));
                    check("cmd_err_in_xfer", 64'(cmd_err), 64'd0);
                    if (e_wr) begin
                        check("pwdata", 64'(pwdata), 64'(e_pwdata));
                        check("pstrb", 64'(pstrb), 64'(e_pstrb));
                    end
                end
            end

            c_fin    = m_busy && m_done && (e_wr ? finish_wr : finish_rd);
            n_setup  = 0;
            n_access = 0;
            n_go     = 0;
            if (c_er) begin
                e_id    = ARID;
                e_addr  = ARADDR[15:0];
                e_paddr = {ARADDR[AW-1:2], 2'b00};
                e_wr    = 0;
                e_err   = (ARLEN != 0) || (ARSIZE > 2);
            end
            if (c_ew) begin
                c_lane   = int'((AWADDR / 4) % (DW / 32));
                e_id     = AWID;
                e_addr   = AWADDR[15:0];
                e_paddr  = {AWADDR[AW-1:2], 2'b00};
                e_wr     = 1;
                e_pwdata = 32'(WDATA >> (32 * c_lane));
                e_pstrb  = 4'(WSTRB >> (4 * c_lane));
                e_err    = (AWLEN != 0) || (AWSIZE > 2) || !WLAST;
            end
            if (c_er || c_ew) begin
                m_busy    = 1;
                m_done    = 0;
                m_acc     = 0;
                m_last_wr = c_ew;
                if (e_err) n_go = 1;
                else       n_setup = 1;
            end
            if (m_setup) n_access = 1;
            if (m_access) begin
                m_acc++;
                if (pready) begin
                    m_done = 1;
                end else if (TO != 0 && m_acc == TO) begin
                    n_go  = 1;
                    e_err = 1;
                end else begin
                    n_access = 1;
                end
            end
            if (m_go) m_done = 1;
            if (c_fin) begin
                m_busy = 0;
                m_done = 0;
            end
            m_setup  = n_setup;
            m_access = n_access;
            m_go     = n_go;
        end
        if (rst) begin
            m_en      = 1;
            m_busy    = 0;
            m_done    = 0;
            m_last_wr = 1;
            m_setup   = 0;
            m_access  = 0;
            m_go      = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds the matching finish until the outstanding command retires.
    task automatic drain(input bit wr);
        bit ok;
        ok = 0;
        pready = 1;
        if (wr) finish_wr = 1;
        else    finish_rd = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            #1;
            if (!m_busy) begin
                ok = 1;
                break;
            end
        end
        finish_wr = 0;
        finish_rd = 0;
        check("drain_done", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    bit was_wr;
    bit seen;
    int n_pen;

    initial begin
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        #1;
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_cmd_err", 64'(cmd_err), 64'd0);
        check("rst_cmd_err_go", 64'(cmd_err_go), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_pstrb", 64'(pstrb), 64'd0);
        check("rst_cmd_id", 64'(cmd_id), 64'd0);
        check("rst_cmd_addr", 64'(cmd_addr), 64'd0);

        // single read, pready already high in SETUP
        ARVALID = 1; ARADDR = 32'h0000_0ABC; ARLEN = 0; ARSIZE = 3'd2; ARID = 6'd5; pready = 1;
        #1;
        check("rd_arready", 64'(ARREADY), 64'd1);
        check("rd_awready", 64'(AWREADY), 64'd0);
        cyc();
        ARVALID = 0;
        #1;
        check("rd_setup_psel", 64'(psel), 64'd1);
        check("rd_setup_penable", 64'(penable), 64'd0);
        check("rd_paddr", 64'(paddr), 64'hABC);
        check("rd_cmd_id", 64'(cmd_id), 64'd5);
        check("rd_cmd_err", 64'(cmd_err), 64'd0);
        check("rd_pwrite", 64'(pwrite), 64'd0);
        cyc();
        #1;
        check("rd_access_psel", 64'(psel), 64'd1);
        check("rd_access_penable", 64'(penable), 64'd1);
        cyc();
        #1;
        check("rd_resp_psel", 64'(psel), 64'd0);
        check("rd_resp_penable", 64'(penable), 64'd0);
        ARVALID = 1; ARADDR = 32'h10; ARID = 6'd7; finish_wr = 1;
        #1;
        check("rd_resp_hold", 64'(ARREADY), 64'd0);
        cyc();
        finish_wr = 0;
        #1;
        check("rd_ignore_finish_wr", 64'(ARREADY), 64'd0);
        finish_rd = 1;
        cyc();
        finish_rd = 0;
        #1;
        check("rd_regrant", 64'(ARREADY), 64'd1);
        check("rd_id_stable", 64'(cmd_id), 64'd5);
        cyc();
        ARVALID = 0;
        #1;
        check("rd2_cmd_id", 64'(cmd_id), 64'd7);
        drain(0);

        // write, upper lane of a 64-bit beat; AW without W must not be accepted
        AWVALID = 1; WVALID = 0; AWADDR = 32'h104; AWID = 6'd9; AWLEN = 0; AWSIZE = 3'd2;
        WLAST = 1; WDATA = 64'hDEADBEEF_12345678; WSTRB = 8'hF0;
        #1;
        check("wr_needs_w", 64'(AWREADY), 64'd0);
        WVALID = 1;
        #1;
        check("wr_awready", 64'(AWREADY), 64'd1);
        check("wr_wready", 64'(WREADY), 64'd1);
        check("wr_arready", 64'(ARREADY), 64'd0);
        cyc();
        AWVALID = 0; WVALID = 0;
        #1;
        check("wr_psel", 64'(psel), 64'd1);
        check("wr_pwrite", 64'(pwrite), 64'd1);
        check("wr_paddr", 64'(paddr), 64'h104);
        check("wr_pwdata", 64'(pwdata), 64'hDEADBEEF);
        check("wr_pstrb", 64'(pstrb), 64'hF);
        check("wr_cmd_id", 64'(cmd_id), 64'd9);
        check("wr_cmd_addr", 64'(cmd_addr), 64'h104);
        drain(1);

        // write, lower lane; address bits above the APB window only reach cmd_addr
        AWVALID = 1; WVALID = 1; AWADDR = 32'h0000_3200; AWID = 6'd12;
        #1;
        cyc();
        AWVALID = 0; WVALID = 0;
        #1;
        check("wr0_pwdata", 64'(pwdata), 64'h12345678);
        check("wr0_pstrb", 64'(pstrb), 64'h0);
        check("wr0_paddr", 64'(paddr), 64'h200);
        check("wr0_cmd_addr", 64'(cmd_addr), 64'h3200);
        drain(1);

        // both paths pending after reset: R, W, R, W
        rst = 1;
        cyc();
        rst = 0;
        ARVALID = 1; ARADDR = 32'h40; ARID = 6'd1;
        AWVALID = 1; WVALID = 1; AWADDR = 32'h80; AWID = 6'd2;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("arb_rd_turn", 64'(ARREADY), 64'(g % 2 == 0));
            check("arb_wr_turn", 64'(AWREADY), 64'(g % 2 == 1));
            was_wr = AWREADY;
            cyc();
            drain(was_wr);
        end
        ARVALID = 0; AWVALID = 0; WVALID = 0;

        // malformed read: no APB transfer, one-cycle error pulse, write waits for finish_rd
        ARVALID = 1; ARADDR = 32'h8; ARLEN = 8'd3; ARID = 6'd4;
        #1;
        check("bad_arready", 64'(ARREADY), 64'd1);
        cyc();
        ARVALID = 0; ARLEN = 0;
        AWVALID = 1; WVALID = 1; AWADDR = 32'h0C; AWID = 6'd3; WLAST = 1;
        #1;
        check("bad_psel", 64'(psel), 64'd0);
        check("bad_cmd_err", 64'(cmd_err), 64'd1);
        check("bad_go", 64'(cmd_err_go), 64'd1);
        check("bad_awready_wait", 64'(AWREADY), 64'd0);
        check("bad_cmd_id", 64'(cmd_id), 64'd4);
        cyc();
        #1;
        check("bad_go_once", 64'(cmd_err_go), 64'd0);
        check("bad_cmd_err_held", 64'(cmd_err), 64'd1);
        finish_wr = 1;
        cyc();
        finish_wr = 0;
        #1;
        check("bad_wrong_finish", 64'(AWREADY), 64'd0);
        drain(0);
        check("bad_next_grant", 64'(AWREADY), 64'd1);
        cyc();
        AWVALID = 0; WVALID = 0;
        #1;
        check("bad_next_psel", 64'(psel), 64'd1);
        check("bad_next_err", 64'(cmd_err), 64'd0);
        drain(1);

        // malformed write (WLAST low) and oversized read
        AWVALID = 1; WVALID = 1; AWADDR = 32'h30; WLAST = 0;
        #1;
        cyc();
        AWVALID = 0; WVALID = 0; WLAST = 1;
        #1;
        check("badw_go", 64'(cmd_err_go), 64'd1);
        check("badw_cmd_err", 64'(cmd_err), 64'd1);
        drain(1);
        ARVALID = 1; ARADDR = 32'h34; ARSIZE = 3'd3;
        #1;
        cyc();
        ARVALID = 0; ARSIZE = 3'd2;
        #1;
        check("badsz_go", 64'(cmd_err_go), 64'd1);
        drain(0);

        // timeout: penable high exactly TO cycles, then error pulse
        ARVALID = 1; ARADDR = 32'h20; ARID = 6'd3; pready = 0;
        #1;
        cyc();
        ARVALID = 0;
        n_pen = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cmd_err_go) begin
                seen = 1;
                break;
            end
            if (penable) n_pen++;
            cyc();
        end
        check("to_go_seen", 64'(seen), 64'd1);
        check("to_penable_cycles", 64'(n_pen), 64'd4);
        check("to_cmd_err", 64'(cmd_err), 64'd1);
        check("to_psel", 64'(psel), 64'd0);
        drain(0);

        // pready on the last allowed ACCESS cycle wins over the timeout
        ARVALID = 1; ARADDR = 32'h24; ARID = 6'd2; pready = 0;
        #1;
        cyc();
        ARVALID = 0;
        repeat (4) cyc();
        pready = 1;
        #1;
        check("to_edge_penable", 64'(penable), 64'd1);
        check("to_edge_go", 64'(cmd_err_go), 64'd0);
        cyc();
        #1;
        check("to_edge_psel", 64'(psel), 64'd0);
        check("to_edge_go_after", 64'(cmd_err_go), 64'd0);
        check("to_edge_cmd_err", 64'(cmd_err), 64'd0);
        cyc();
        #1;
        check("to_edge_go_late", 64'(cmd_err_go), 64'd0);
        drain(0);

        // reset in the middle of ACCESS
        ARVALID = 1; ARADDR = 32'h30; ARID = 6'd10; pready = 0;
        #1;
        cyc();
        ARVALID = 0;
        cyc();
        #1;
        check("rstx_penable_before", 64'(penable), 64'd1);
        rst = 1;
        cyc();
        rst = 0;
        #1;
        check("rstx_psel", 64'(psel), 64'd0);
        check("rstx_penable", 64'(penable), 64'd0);
        check("rstx_arready", 64'(ARREADY), 64'd0);
        check("rstx_cmd_id", 64'(cmd_id), 64'd0);
        check("rstx_cmd_err", 64'(cmd_err), 64'd0);
        cyc();
        #1;
        check("rstx_idle_psel", 64'(psel), 64'd0);
        check("rstx_idle_arready", 64'(ARREADY), 64'd0);
        ARVALID = 1; AWVALID = 1; WVALID = 1;
        #1;
        check("rstx_read_first", 64'(ARREADY), 64'd1);
        check("rstx_write_waits", 64'(AWREADY), 64'd0);
        cyc();
        ARVALID = 0; AWVALID = 0; WVALID = 0;
        drain(0);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi2apb_cmd_ctrl.md
Name: axi2apb_cmd_ctrl

Overview:
- Command controller for the AXI-to-APB bridge.
- Accepts single-beat AXI read (AR) and write (AW+W) requests, arbitrates round-robin between the read and write paths, and sequences the APB SETUP/ACCESS phases.
- Presents cmd_id/cmd_addr/cmd_err to the downstream read and write response stages, and holds the next command until that stage reports completion (finish_rd/finish_wr).
- Also handles malformed requests and APB slave timeouts without hanging the bus.

Parameters:
- AXI_ID_WIDTH, 6, AXI ID width.
- AXI_DATA_WIDTH, 64, AXI data width; power of two, 32..512.
- APB_ADDR_WIDTH, 12, APB address width (4KB slave window).
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before forced error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ARID  in  AXI_ID_WIDTH  read ID.
- ARADDR  in  32  read address.
- ARLEN  in  8  read burst length.
- ARSIZE  in  3  read beat size.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accept.
- AWID  in  AXI_ID_WIDTH  write ID.
- AWADDR  in  32  write address.
- AWLEN  in  8  write burst length.
- AWSIZE  in  3  write beat size.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accept.
- WDATA  in  AXI_DATA_WIDTH  write data.
- WSTRB  in  AXI_DATA_WIDTH/8  write byte strobes.
- WLAST  in  1  last write beat.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accept.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction, 1 = write.
- paddr  out  APB_ADDR_WIDTH  APB address.
- pwdata  out  32  APB write data.
- pstrb  out  4  APB byte strobes.
- pready  in  1  APB ready.
- cmd_id  out  AXI_ID_WIDTH  ID of the current command.
- cmd_addr  out  APB_ADDR_WIDTH+4  AxADDR[APB_ADDR_WIDTH+3:0] of the current command.
- cmd_err  out  1  current command is malformed or timed out.
- cmd_err_go  out  1  one-cycle pulse telling the response stage to issue an error response with no APB transfer.
- finish_rd  in  1  read response completed.
- finish_wr  in  1  write response completed.

Behaviour:
- Reset (rst high at a clk edge) forces:
  - outputs: psel, penable, pwrite, cmd_err, cmd_err_go = 0; paddr, pwdata, pstrb, cmd_id, cmd_addr = 0.
  - internals: state = IDLE; last_grant = WRITE, so a read wins the first tie; timeout counter = 0.
  - Reset mid-transfer aborts the transfer; no completion is reported.
- Request readiness:
  - Read request pending = ARVALID.
  - Write request pending = AWVALID & WVALID (AW and W are consumed together).
- Arbitration (IDLE only):
  - If only one side is pending, grant it.
  - If both are pending, grant the side opposite last_grant.
- Handshake signals (combinational, asserted only in IDLE on the grant cycle):
  - ARREADY = 1 for a read grant.
  - AWREADY = WREADY = 1, in the same cycle, for a write grant.
  - All three are 0 in every other state.
- Capture on grant: cmd_id, cmd_addr, pwrite, and last_grant are registered.
- Error classification: err = (AxLEN != 0) | (AxSIZE > 2), plus for writes (WLAST == 0).
- Write lane select:
  - lane = AWADDR[2 +: log2(AXI_DATA_WIDTH/32)], or 0 when AXI_DATA_WIDTH is 32.
  - pwdata = WDATA[32*lane +: 32]; pstrb = WSTRB[4*lane +: 4].
  - paddr = {AxADDR[APB_ADDR_WIDTH-1:2], 2'b00}.
- State machine:
  - IDLE → SETUP on grant with err = 0; cmd_err <= 0.
  - IDLE → ERR on grant with err = 1; cmd_err <= 1.
  - SETUP: psel = 1, penable = 0; always → ACCESS.
  - ACCESS: psel = 1, penable = 1; counter increments each cycle.
    - pready = 1 → RESP; psel = penable = 0 next cycle.
    - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 → ERR; cmd_err <= 1; psel = penable = 0.
  - ERR: cmd_err_go = 1 for exactly this cycle; → RESP.
  - RESP: wait for finish_rd (read command) or finish_wr (write command).
    - On that event → IDLE; counter cleared.
    - The opposite finish signal is ignored.
- Latency:
  - Grant to psel rising: 1 cycle.
  - Minimum APB transfer: 2 cycles.
  - A new grant is possible in the cycle after finish.
- cmd_id and cmd_addr stay stable from the cycle after grant until the next grant.
- pready in SETUP is ignored.
- A pready that arrives together with the timeout expiry wins: normal RESP, cmd_err = 0.

Decomposition:
- Package axi2apb_pkg holds:
  - state enum: IDLE, SETUP, ACCESS, ERR, RESP;
  - grant enum: READ, WRITE;
  - RESP_OK, RESP_SLVERR, RESP_DECERR;
  - lane-count function replacing the log2 macro.
- One sub-module, axi2apb_rr_arb: 2-input round-robin arbiter with a last_grant register and an advance input.

Test Plan:
- Read only: ARVALID=1, ARADDR=0x0000_0ABC, ARLEN=0, ARSIZE=2, ARID=5; pready=1 in ACCESS → ARREADY one cycle; paddr=0xABC; psel high 2 cycles; cmd_id=5; cmd_err=0; holds in RESP until finish_rd.
- Write lane select, 64-bit: AWADDR=0x104, WDATA=0xDEADBEEF_12345678, WSTRB=0xF0 → pwdata=0xDEADBEEF; pstrb=0xF; pwrite=1; AWREADY and WREADY in the same cycle.
- Simultaneous AR and AW+W after reset → read granted first, write granted after finish_rd; repeat with both pending → alternates R, W, R, W.
- Malformed: ARLEN=3 → no psel; cmd_err=1; cmd_err_go pulses exactly 1 cycle; next grant only after finish_rd.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 → penable high exactly 4 cycles; then cmd_err=1 and cmd_err_go pulse. Variant with pready=1 on the 4th ACCESS cycle → normal completion, cmd_err=0.
- rst=1 during ACCESS → next cycle psel=penable=0, state IDLE, ARREADY=0 until a new grant.
